// File: rtl/quadrature_encoder.sv
// Quadrature encoder interface: synchronised, glitch-filtered A/B/Z decoded x4 into a signed position counter, Avalon-MM register map.
// Latency: pin to POSITION/INDEX_LATCH is FILTER_LEN+3 clocks; register reads return one cycle after the address is sampled.
// Backpressure: none, waitrequest is tied low. Optional velocity window logic is built when QENC_VELOCITY_EN is defined.
module quadrature_encoder #(
  parameter int CNT_WIDTH  = 32,
  parameter int FILTER_LEN = 4,
  parameter int ERR_WIDTH  = 16
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [31:0] avs_ctrl_writedata,
  output logic [31:0] avs_ctrl_readdata,
  input  logic [3:0]  avs_ctrl_byteenable,
  input  logic [2:0]  avs_ctrl_address,
  input  logic        avs_ctrl_write,
  input  logic        avs_ctrl_read,
  output logic        avs_ctrl_waitrequest,
  input  logic        A,
  input  logic        B,
  input  logic        Z
);

  localparam logic [31:0]          ID_VAL  = 32'hEA680004;
  localparam logic [3:0]           FLT_MAX = 4'(FILTER_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] POS_ONE = CNT_WIDTH'(1);

  // Pin order in the vectors below: [2] = A, [1] = B, [0] = Z.
  logic [2:0] sync1, sync2, filt;
  logic [3:0] fcnt [3];
  logic [1:0] prev_ab;
  logic       prev_z;

  logic [CNT_WIDTH-1:0] pos, idx_latch;
  logic [ERR_WIDTH-1:0] err_cnt;
  logic [2:0]           ctrl;     // {inv, zclr, en}
  logic                 st_dir, st_err, st_idx;

  logic [31:0] window_q, velocity_q;

  logic fwd, rev, illegal, up, dn, z_rise;
  logic wr_pos, wr_stat, wr_ctrl, wr_err, wr_win;

  assign avs_ctrl_waitrequest = 1'b0;

  assign wr_pos  = avs_ctrl_write && (avs_ctrl_address == 3'd1);
  assign wr_stat = avs_ctrl_write && (avs_ctrl_address == 3'd2);
  assign wr_ctrl = avs_ctrl_write && (avs_ctrl_address == 3'd3);
  assign wr_err  = avs_ctrl_write && (avs_ctrl_address == 3'd5);
  assign wr_win  = avs_ctrl_write && (avs_ctrl_address == 3'd7);

  // Two-stage synchroniser and per-pin persistence filter.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 3; i++) fcnt[i] <= '0;
    end else begin
      sync1 <= {A, B, Z};
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FLT_MAX) begin
          filt[i] <= sync2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 4'd1;
        end
      end
    end
  end

  // x4 decode of previous versus current filtered {A,B}; both bits moving together is illegal.
  always_comb begin
    fwd = 1'b0;
    rev = 1'b0;
    case ({prev_ab, filt[2:1]})
      4'b0010, 4'b1011, 4'b1101, 4'b0100: fwd = 1'b1;
      4'b1000, 4'b1110, 4'b0111, 4'b0001: rev = 1'b1;
      default: ;
    endcase
    illegal = ((prev_ab ^ filt[2:1]) == 2'b11);
    up      = ctrl[0] && (ctrl[2] ? rev : fwd);
    dn      = ctrl[0] && (ctrl[2] ? fwd : rev);
    z_rise  = filt[0] && !prev_z;
  end

  // Position, index capture, error counter, status and control registers.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      prev_ab   <= 2'b00;
      prev_z    <= 1'b0;
      pos       <= '0;
      idx_latch <= '0;
      err_cnt   <= '0;
      ctrl      <= 3'b001;
      st_dir    <= 1'b0;
      st_err    <= 1'b0;
      st_idx    <= 1'b0;
    end else begin
      prev_ab <= filt[2:1];
      prev_z  <= filt[0];

      // Bus write beats index clear, which beats the decoder step.
      if (wr_pos)                 pos <= avs_ctrl_writedata[CNT_WIDTH-1:0];
      else if (z_rise && ctrl[1]) pos <= '0;
      else if (up)                pos <= pos + POS_ONE;
      else if (dn)                pos <= pos - POS_ONE;

      if (z_rise) idx_latch <= pos;

      if (wr_err)                       err_cnt <= '0;
      else if (illegal && ~&err_cnt)    err_cnt <= err_cnt + ERR_WIDTH'(1);

      if (up)      st_dir <= 1'b1;
      else if (dn) st_dir <= 1'b0;

      // Sticky flags: a set event in the clearing cycle wins.
      st_err <= illegal || (st_err && !(wr_stat && avs_ctrl_writedata[1]));
      st_idx <= z_rise  || (st_idx && !(wr_stat && avs_ctrl_writedata[2]));

      if (wr_ctrl && avs_ctrl_byteenable[0]) ctrl <= avs_ctrl_writedata[2:0];
    end
  end

`ifdef QENC_VELOCITY_EN
  logic [31:0]        win_cnt;
  logic signed [31:0] acc, acc_nxt;

  // Saturating accumulation of the counted steps.
  always_comb begin
    acc_nxt = acc;
    if (up && acc != 32'sh7FFF_FFFF)      acc_nxt = acc + 32'sd1;
    else if (dn && acc != 32'sh8000_0000) acc_nxt = acc - 32'sd1;
  end

  // WINDOW register with byte-lane writes.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      window_q <= 32'd1_000_000;
    end else if (wr_win) begin
      for (int i = 0; i < 4; i++)
        if (avs_ctrl_byteenable[i]) window_q[8*i +: 8] <= avs_ctrl_writedata[8*i +: 8];
    end
  end

  // Window counter: VELOCITY takes the net step count at each window end.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      win_cnt    <= '0;
      acc        <= '0;
      velocity_q <= '0;
    end else if (wr_win) begin
      win_cnt <= '0;
      acc     <= '0;
    end else if (window_q == 32'd0) begin
      win_cnt    <= '0;
      acc        <= '0;
      velocity_q <= '0;
    end else if (win_cnt == window_q - 32'd1) begin
      win_cnt    <= '0;
      acc        <= '0;
      velocity_q <= acc_nxt;
    end else begin
      win_cnt <= win_cnt + 32'd1;
      acc     <= acc_nxt;
    end
  end
`else
  assign window_q   = 32'd0;
  assign velocity_q = 32'd0;
`endif

  // Registered read mux; follows the address regardless of the read strobe.
  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      avs_ctrl_readdata <= '0;
    end else begin
      case (avs_ctrl_address)
        3'd0:    avs_ctrl_readdata <= ID_VAL;
        3'd1:    avs_ctrl_readdata <= 32'(signed'(pos));
        3'd2:    avs_ctrl_readdata <= {29'd0, st_idx, st_err, st_dir};
        3'd3:    avs_ctrl_readdata <= {29'd0, ctrl};
        3'd4:    avs_ctrl_readdata <= 32'(signed'(idx_latch));
        3'd5:    avs_ctrl_readdata <= 32'(err_cnt);
        3'd6:    avs_ctrl_readdata <= velocity_q;
        default: avs_ctrl_readdata <= window_q;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{avs_ctrl_read, avs_ctrl_writedata, avs_ctrl_byteenable};

endmodule

// File: doc/quadrature_encoder.md
# quadrature_encoder

Parametrised quadrature-encoder interface on the Qsys control bus. It is the next generation of the single-counter position encoder block, and the whole block runs in the system clock domain. A, B and Z are synchronised and glitch-filtered, then decoded at ×4 resolution into a wide signed position counter. The block also provides index capture, illegal-transition detection and an optional velocity measurement, all behind an Avalon-MM register map.

## Interface
Parameters:
- CNT_WIDTH, 32: position counter width, legal range 8–32; read back sign-extended to 32 bits.
- FILTER_LEN, 4: consecutive identical synchronised samples required before a filtered input changes, legal range 1–15.
- ERR_WIDTH, 16: width of the illegal-transition counter, which saturates.

Ports:
- csi_MCLK_clk, in, 1: the single clock; every register is on its rising edge.
- rsi_MRST_reset, in, 1: synchronous, active-high reset.
- avs_ctrl_writedata, in, 32: write data.
- avs_ctrl_readdata, out, 32: registered read data; reset value 0.
- avs_ctrl_byteenable, in, 4: byte lanes, honoured on writes to CONTROL and WINDOW.
- avs_ctrl_address, in, 3: word address into the register map.
- avs_ctrl_write, in, 1: write strobe.
- avs_ctrl_read, in, 1: read strobe.
- avs_ctrl_waitrequest, out, 1: constant 0.
- A, B, Z, in, 1 each: asynchronous encoder pins.

## Operation
- Input path: each pin passes through a 2-FF synchroniser, then a per-pin filter counter. The filtered value takes a new level only after FILTER_LEN consecutive cycles at that level. Filtered values reset to 0.
- Decoder: compares the previous filtered {A,B} with the current one.
  - Forward sequence is 00→10→11→01→00, giving +1 per step.
  - The reverse sequence gives −1 per step.
  - No change gives no step.
  - A change of both bits at once is an illegal transition: no step, ERROR_COUNT increments (saturating at all-ones), and STATUS.err is set.
- CONTROL.inv swaps the +1 and −1 outcomes. With CONTROL.en = 0, steps are discarded but illegal-transition detection stays active.
- Position arithmetic: POSITION is modulo 2^CNT_WIDTH and wraps silently. STATUS.dir records the sign of the last counted step (1 = +1).
- Index: a rising edge of filtered Z does the following.
  - Copies the pre-update POSITION into INDEX_LATCH.
  - Sets STATUS.idx.
  - If CONTROL.zclr = 1, loads POSITION with 0 instead of applying that cycle's step.
- Update priority on POSITION in a single cycle:
  1. Bus write.
  2. Index clear.
  3. Decoder step.
- Register map (word addresses; reset values in parentheses):
  - 0 ID, RO: 32'hEA680004.
  - 1 POSITION, RW: (0).
  - 2 STATUS: bit0 dir RO; bit1 err and bit2 idx are sticky, write-1-to-clear. A set event in the same cycle as a clear wins. (0)
  - 3 CONTROL, RW: bit0 en, bit1 zclr, bit2 inv. (0x1)
  - 4 INDEX_LATCH, RO: (0).
  - 5 ERROR_COUNT, RO; any write clears it to 0. (0)
  - 6 VELOCITY, RO: (0).
  - 7 WINDOW, RW: (32'd1_000_000).
- Reads of unused bits return 0. Writes to RO registers are ignored, except ERROR_COUNT.

## Timing
- Read latency: readdata reflects the address presented at a rising edge from the next cycle on, regardless of avs_ctrl_read. No wait states.
- Writes take effect on the clock edge at which write is sampled. A read of the same register on the next cycle returns the new value.
- Pin-to-POSITION latency is FILTER_LEN+3 clocks: 2 synchroniser stages, FILTER_LEN filter cycles, and 1 decode/update cycle. Z-to-INDEX_LATCH latency is identical.
- Maximum countable edge rate is one filtered transition per FILTER_LEN+1 clocks. Anything faster is either rejected by the filter or reported as illegal.
- Reset mid-operation: all registers return to their reset values on the next edge, and the filters restart from 0. The first post-reset step is decoded only after a filtered change from 00.

## Configuration
- QENC_VELOCITY_EN defined:
  - A free-running window counter counts WINDOW clocks. At each window end, VELOCITY is loaded with the signed net step count over that window (32-bit, saturating) and the accumulator restarts.
  - A write to WINDOW restarts the window. WINDOW = 0 holds VELOCITY at 0.
- QENC_VELOCITY_EN undefined: the window logic is absent. VELOCITY reads 0, WINDOW reads 0, and writes to WINDOW are ignored.

## Test plan
- Reset, then read addresses 0–7 → 0xEA680004, 0, 0, 0x1, 0, 0, 0, and 1_000_000 (0 without QENC_VELOCITY_EN).
- 100 forward ×4 steps, FILTER_LEN = 4 → POSITION = 100, dir = 1; then 150 reverse steps → POSITION = 0xFFFFFFCE (−50), dir = 0.
- 1-cycle and 3-cycle glitches on A (FILTER_LEN = 4) → POSITION unchanged; A changing to 10 at the same time B changes to 01 → ERROR_COUNT = 1, err = 1; writing 0x2 to STATUS → err = 0.
- Z pulse with zclr = 1 at POSITION = 37 → INDEX_LATCH = 37, POSITION = 0, idx = 1; a POSITION write in the same cycle as the Z edge → the written value wins.
- CNT_WIDTH = 8, 130 forward steps → POSITION reads 0xFFFFFF82; inv = 1 and 2 forward steps → 0xFFFFFF80.
- With QENC_VELOCITY_EN and WINDOW = 1000: a forward step every 20 clocks → VELOCITY = 50 after each window end.
